// File: rtl/bcd_subtractor_serial.sv
// Digit-serial packed-BCD subtractor producing |A-B| and a sign flag.
// One digit per clock, LSD first; a negative raw result gets a ten's-complement pass.
module bcd_subtractor_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   DIFF,
    output logic                  NEG,
    output logic                  ERR
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUB,
        S_NEG,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   a_q, a_d;
    logic [4*DIGITS-1:0]   b_q, b_d;
    logic [4*DIGITS-1:0]   diff_q, diff_d;
    logic                  neg_q, neg_d;
    logic                  err_q, err_d;
    logic                  borrow_q, borrow_d;
    logic [IW-1:0]         idx_q, idx_d;

    logic [3:0]            lhs_digit;
    logic [3:0]            rhs_digit;
    logic [4:0]            t;
    logic [3:0]            digit;
    logic                  borrow_out;

    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] a,
                                           input logic [4*DIGITS-1:0] b);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            borrow_q <= borrow_d;
            idx_q    <= idx_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        diff_d     = diff_q;
        neg_d      = neg_q;
        err_d      = err_q;
        borrow_d   = borrow_q;
        idx_d      = idx_q;
        lhs_digit  = 4'd0;
        rhs_digit  = 4'd0;

        // SUB computes A[i]-B[i]; NEG computes 0-DIFF[i], both minus the running borrow.
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx_q) begin
                lhs_digit = (state_q == S_SUB) ? a_q[i*4 +: 4] : 4'd0;
                rhs_digit = (state_q == S_SUB) ? b_q[i*4 +: 4] : diff_q[i*4 +: 4];
            end
        end
        t          = {1'b0, lhs_digit} - {1'b0, rhs_digit} - {4'd0, borrow_q};
        borrow_out = t[4];
        digit      = borrow_out ? (t[3:0] + 4'd10) : t[3:0];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = 1'b0;
                    idx_d    = '0;
                    neg_d    = 1'b0;
                    if (has_bad_digit(A, B)) begin
                        err_d   = 1'b1;
                        diff_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_SUB;
                    end
                end
            end
            S_SUB, S_NEG: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (IW'(i) == idx_q) diff_d[i*4 +: 4] = digit;
                end
                borrow_d = borrow_out;
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    if (state_q == S_NEG) begin
                        neg_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (borrow_out) begin
                        state_d = S_NEG;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign DIFF = diff_q;
    assign NEG  = neg_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Scoreboard bench for bcd_subtractor_serial: stimulus pushes expected results,
// a monitor pops one entry per done pulse and checks value, flags and latency.
module tb_bcd_subtractor_serial;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] DIFF;
    logic         NEG;
    logic         ERR;

    typedef struct {
        logic [W-1:0] diff;
        logic         neg;
        logic         err;
        int           done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   cyc      = 0;

    bcd_subtractor_serial #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .DIFF  (DIFF),
        .NEG   (NEG),
        .ERR   (ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("diff",        64'(DIFF), 64'(e.diff));
                    check("neg",         64'(NEG),  64'(e.neg));
                    check("err",         64'(ERR),  64'(e.err));
                    check("busy_in_done", 64'(busy), 64'd1);
                    check("latency",     64'(cyc),  64'(e.done_cyc));
                end
            end
        end
    end

    // Called on a falling edge while the DUT is idle.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                         input logic [W-1:0] ed, input logic en, input logic ee, input int lat);
        exp_t e;
        A     = a;
        B     = b;
        start = 1'b1;
        if (push) begin
            e.diff     = ed;
            e.neg      = en;
            e.err      = ee;
            e.done_cyc = cyc + lat;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int prev);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (n_done != prev) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ed, input logic en, input logic ee, input int lat);
        int prev;
        prev = n_done;
        @(negedge clk);
        issue(a, b, 1'b1, ed, en, ee, lat);
        @(negedge clk);
        start = 1'b0;
        wait_done(prev);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        bit hit;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_diff", 64'(DIFF), 64'd0);
        check("reset_neg",  64'(NEG),  64'd0);
        check("reset_err",  64'(ERR),  64'd0);

        // Directed vectors: {A, B, DIFF, NEG, ERR, latency}
        run_op(16'h0123, 16'h0045, 16'h0078, 1'b0, 1'b0, 5);
        run_op(16'h0045, 16'h0123, 16'h0078, 1'b1, 1'b0, 9);
        run_op(16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 9);
        run_op(16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 5);
        run_op(16'h00A0, 16'h0001, 16'h0000, 1'b0, 1'b1, 1);
        run_op(16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 5);
        run_op(16'h0001, 16'h1000, 16'h0999, 1'b1, 1'b0, 9);
        run_op(16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 5);
        run_op(16'h0001, 16'h000F, 16'h0000, 1'b0, 1'b1, 1);
        run_op(16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 9);
        run_op(16'h5000, 16'h4999, 16'h0001, 1'b0, 1'b0, 5);
        run_op(16'h2468, 16'h1357, 16'h1111, 1'b0, 1'b0, 5);
        run_op(16'h1357, 16'h2468, 16'h1111, 1'b1, 1'b0, 9);
        run_op(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 5);

        // Results hold after done while idle.
        repeat (3) @(negedge clk);
        check("hold_diff", 64'(DIFF), 64'h0000);
        check("hold_busy", 64'(busy), 64'd0);
        run_op(16'h0045, 16'h0123, 16'h0078, 1'b1, 1'b0, 9);
        repeat (3) @(negedge clk);
        check("hold_diff_neg", 64'(DIFF), 64'h0078);
        check("hold_neg",      64'(NEG),  64'd1);

        // Start while busy is ignored.
        prev = n_done;
        @(negedge clk);
        issue(16'h0123, 16'h0045, 1'b1, 16'h0078, 1'b0, 1'b0, 5);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        issue(16'h9999, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
        @(negedge clk);
        start = 1'b0;
        wait_done(prev);
        check("busy_start_ignored", 64'(busy), 64'd0);

        // Start during the done cycle is ignored.
        @(negedge clk);
        issue(16'h0500, 16'h0200, 1'b1, 16'h0300, 1'b0, 1'b0, 5);
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (done) hit = 1'b1;
        end
        if (!hit) check("done_timeout", 64'd0, 64'd1);
        issue(16'h0045, 16'h0123, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
        @(negedge clk);
        start = 1'b0;
        check("done_start_ignored", 64'(busy), 64'd0);
        check("done_start_diff",    64'(DIFF), 64'h0300);

        // Mid-operation reset aborts without a done pulse.
        prev = n_done;
        @(negedge clk);
        issue(16'h0045, 16'h0123, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_diff", 64'(DIFF), 64'd0);
        check("abort_neg",  64'(NEG),  64'd0);
        check("abort_err",  64'(ERR),  64'd0);
        repeat (12) @(negedge clk);
        check("abort_no_done", 64'(n_done), 64'(prev));

        run_op(16'h0100, 16'h0001, 16'h0099, 1'b0, 1'b0, 5);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
